// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared widths and dispatcher state encoding for the fib engine slice
package fib_pkg;

    localparam int FIB_N_WIDTH      = 6;
    localparam int FIB_RESULT_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ARM,
        ST_WAIT,
        ST_HOLD
    } fib_state_t;

endpackage

// File: rtl/fib_req_fifo.sv
// rtl/fib_req_fifo.sv - request FIFO with wrapping pointers and occupancy count
module fib_req_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fib_dispatcher.sv
// rtl/fib_dispatcher.sv - queues fib requests, drives the engine, captures results with a watchdog
module fib_dispatcher
    import fib_pkg::*;
#(
    parameter int N_WIDTH      = FIB_N_WIDTH,
    parameter int RESULT_WIDTH = FIB_RESULT_WIDTH,
    parameter int DEPTH        = 4,
    parameter int TIMEOUT      = 1023,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [N_WIDTH-1:0]      req_n,
    output logic                    fib_go,
    output logic [N_WIDTH-1:0]      fib_n,
    input  logic [RESULT_WIDTH-1:0] fib_result,
    input  logic                    fib_overflow,
    input  logic                    fib_done,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [N_WIDTH-1:0]      rsp_n,
    output logic [RESULT_WIDTH-1:0] rsp_result,
    output logic                    rsp_overflow,
    output logic                    rsp_timeout,
    output logic [CW-1:0]           pending
);

    fib_state_t         state;
    logic [WW-1:0]      wd_count;
    logic [N_WIDTH-1:0] fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;

    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
    assign req_ready = !fifo_full;

    fib_req_fifo #(
        .WIDTH (N_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_valid),
        .push_data (req_n),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (pending)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            wd_count     <= '0;
            fib_go       <= 1'b0;
            fib_n        <= '0;
            rsp_valid    <= 1'b0;
            rsp_n        <= '0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_timeout  <= 1'b0;
        end else begin
            fib_go <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fib_n <= fifo_head;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    fib_go <= 1'b1;
                    state  <= ST_ARM;
                end
                // The engine sees go at the end of this cycle; any done seen here is left over.
                ST_ARM: begin
                    wd_count <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (fib_done) begin
                        rsp_n        <= fib_n;
                        rsp_result   <= fib_result;
                        rsp_overflow <= fib_overflow;
                        rsp_timeout  <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= ST_HOLD;
                    end else if (wd_count == WW'(TIMEOUT - 1)) begin
                        rsp_n        <= fib_n;
                        rsp_result   <= '0;
                        rsp_overflow <= 1'b1;
                        rsp_timeout  <= 1'b1;
                        rsp_valid    <= 1'b1;
                        state        <= ST_HOLD;
                    end else begin
                        wd_count <= wd_count + WW'(1);
                    end
                end
                ST_HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_dispatcher.sv
// tb/tb_fib_dispatcher.sv - directed self-checking bench for fib_dispatcher with a behavioural engine
module tb_fib_dispatcher;

    localparam int NW = 6;
    localparam int RW = 32;
    localparam int DP = 4;
    localparam int TO = 15;
    localparam int CW = $clog2(DP + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [NW-1:0] req_n = '0;
    logic          fib_go;
    logic [NW-1:0] fib_n;
    logic [RW-1:0] fib_result = '0;
    logic          fib_overflow = 1'b0;
    logic          fib_done = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [NW-1:0] rsp_n;
    logic [RW-1:0] rsp_result;
    logic          rsp_overflow;
    logic          rsp_timeout;
    logic [CW-1:0] pending;

    int checks = 0;
    int failures = 0;

    logic        eng_mute = 1'b0;
    logic        stale_req = 1'b0;
    logic [63:0] eng_val = '0;
    int          eng_cnt = 0;

    always #5 clk = ~clk;

    fib_dispatcher #(
        .N_WIDTH      (NW),
        .RESULT_WIDTH (RW),
        .DEPTH        (DP),
        .TIMEOUT      (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_n        (req_n),
        .fib_go       (fib_go),
        .fib_n        (fib_n),
        .fib_result   (fib_result),
        .fib_overflow (fib_overflow),
        .fib_done     (fib_done),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_n        (rsp_n),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_timeout  (rsp_timeout),
        .pending      (pending)
    );

    function automatic logic [63:0] fib_model(input logic [NW-1:0] n);
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] t;
        a = 64'd0;
        b = 64'd1;
        for (int i = 0; i < int'(n); i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Engine: done level drops on go and returns two cycles later; mute keeps it low.
    always @(posedge clk) begin
        if (stale_req) begin
            fib_done     <= 1'b1;
            fib_result   <= 32'hDEADBEEF;
            fib_overflow <= 1'b0;
        end else if (fib_go) begin
            fib_done <= 1'b0;
            eng_val  <= fib_model(fib_n);
            eng_cnt  <= eng_mute ? 0 : 2;
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) begin
                fib_done     <= 1'b1;
                fib_result   <= eng_val[RW-1:0];
                fib_overflow <= (eng_val[63:RW] != '0);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [NW-1:0] n);
        req_n     = n;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic [NW-1:0] n, input logic ovf,
                           input logic tmo, output logic [RW-1:0] res);
        int k = 0;
        while (rsp_valid !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_valid"}, 64'(rsp_valid), 64'(1));
        check({tag, "_n"}, 64'(rsp_n), 64'(n));
        check({tag, "_ovf"}, 64'(rsp_overflow), 64'(ovf));
        check({tag, "_tmo"}, 64'(rsp_timeout), 64'(tmo));
        res       = rsp_result;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_drop"}, 64'(rsp_valid), 64'(0));
    endtask

    logic [RW-1:0] res;
    int            k;
    int            seen;
    logic [RW-1:0] exp_fib [1:5];

    initial begin
        exp_fib[1] = 32'd1;
        exp_fib[2] = 32'd1;
        exp_fib[3] = 32'd2;
        exp_fib[4] = 32'd3;
        exp_fib[5] = 32'd5;

        repeat (3) @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'(1));
        check("rst_pending", 64'(pending), 64'(0));
        check("rst_go", 64'(fib_go), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        rst = 1'b1;
        @(negedge clk);

        // n=10: issue latency, done-to-response latency, result
        push(6'd10);
        k = 1;
        while (fib_go !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("go_latency", 64'(k), 64'(3));
        check("go_fib_n", 64'(fib_n), 64'(10));
        k = 0;
        while (rsp_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("rsp_latency", 64'(k), 64'(4));
        get_rsp("n10", 6'd10, 1'b0, 1'b0, res);
        check("n10_result", 64'(res), 64'(55));

        // Overflow
        push(6'd50);
        get_rsp("n50", 6'd50, 1'b1, 1'b0, res);

        // Stale done held across go must not be captured
        stale_req = 1'b1;
        @(negedge clk);
        stale_req = 1'b0;
        push(6'd5);
        get_rsp("stale", 6'd5, 1'b0, 1'b0, res);
        check("stale_result", 64'(res), 64'(5));

        // Full FIFO with back-pressure, then in-order drain
        for (int i = 1; i <= 6; i++) begin
            req_n     = NW'(i);
            req_valid = 1'b1;
            check($sformatf("full_ready%0d", i), 64'(req_ready), 64'((i == 6) ? 0 : 1));
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("full_pending", 64'(pending), 64'(4));
        for (int i = 1; i <= 5; i++) begin
            get_rsp($sformatf("drain%0d", i), NW'(i), 1'b0, 1'b0, res);
            check($sformatf("drain%0d_result", i), 64'(res), 64'(exp_fib[i]));
        end
        check("drain_pending", 64'(pending), 64'(0));

        // Watchdog
        eng_mute = 1'b1;
        push(6'd3);
        k = 0;
        while (fib_go !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (rsp_valid !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("tmo_latency", 64'(k), 64'(TO + 1));
        get_rsp("tmo", 6'd3, 1'b1, 1'b1, res);
        check("tmo_result", 64'(res), 64'(0));

        // Reset in WAIT with two queued entries
        push(6'd7);
        push(6'd8);
        push(6'd9);
        repeat (3) @(negedge clk);
        check("pre_rst_pending", 64'(pending), 64'(2));
        #2 rst = 1'b0;
        #1;
        check("mid_rst_pending", 64'(pending), 64'(0));
        check("mid_rst_ready", 64'(req_ready), 64'(1));
        check("mid_rst_go", 64'(fib_go), 64'(0));
        check("mid_rst_fib_n", 64'(fib_n), 64'(0));
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("mid_rst_rsp_n", 64'(rsp_n), 64'(0));
        check("mid_rst_rsp_result", 64'(rsp_result), 64'(0));
        check("mid_rst_rsp_ovf", 64'(rsp_overflow), 64'(0));
        check("mid_rst_rsp_tmo", 64'(rsp_timeout), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid || fib_go) seen++;
        end
        check("post_rst_quiet", 64'(seen), 64'(0));

        // First request after reset release
        eng_mute = 1'b0;
        push(6'd12);
        get_rsp("post_rst", 6'd12, 1'b0, 1'b0, res);
        check("post_rst_result", 64'(res), 64'(144));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fib_dispatcher.md
FIB_DISPATCHER -- requirements
Module: fib_dispatcher

Interface
REQ-001 Parameter N_WIDTH, 6, width of the requested sequence index n.
REQ-002 Parameter RESULT_WIDTH, 32, width of the fib result.
REQ-003 Parameter DEPTH, 4, request FIFO depth; power of two, at least 2.
REQ-004 Parameter TIMEOUT, 1023, maximum WAIT cycles before the dispatcher abandons a computation.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-low; one clock; asserts asynchronously, no synchronous reset term anywhere.
REQ-007 req_valid  in  1  upstream request valid.
REQ-008 req_ready  out  1  request FIFO can accept.
REQ-009 req_n  in  N_WIDTH  requested index.
REQ-010 fib_go  out  1  start pulse to the fib engine.
REQ-011 fib_n  out  N_WIDTH  index presented to the fib engine.
REQ-012 fib_result  in  RESULT_WIDTH  engine result.
REQ-013 fib_overflow  in  1  engine overflow flag.
REQ-014 fib_done  in  1  engine done level.
REQ-015 rsp_valid  out  1  response valid.
REQ-016 rsp_ready  in  1  downstream accepts the response.
REQ-017 rsp_n  out  N_WIDTH  echo of the index that produced the response.
REQ-018 rsp_result  out  RESULT_WIDTH  captured result.
REQ-019 rsp_overflow  out  1  captured overflow flag; forced to 1 on timeout.
REQ-020 rsp_timeout  out  1  response was produced by the watchdog.
REQ-021 pending  out  $clog2(DEPTH+1)  FIFO occupancy.

Function
REQ-022 A request SHALL be accepted on a rising edge with req_valid && req_ready; req_ready SHALL equal (pending != DEPTH), with no combinational path from any input.
REQ-023 The FIFO SHALL use wrapping read and write pointers; a push and a pop in the same cycle SHALL leave pending unchanged.
REQ-024 The FSM SHALL have the states IDLE, ISSUE, ARM, WAIT and HOLD.
REQ-025 IDLE: if pending != 0, go to ISSUE and pop the FIFO head into the fib_n register.
REQ-026 ISSUE: fib_go=1 for exactly this one cycle, then go to ARM.
REQ-027 ARM: a one-cycle blanking state in which fib_done is ignored, so a stale done from the previous run is never captured; then go to WAIT.
REQ-028 WAIT: on fib_done=1, capture fib_result, fib_overflow and fib_n into the rsp_* registers with rsp_timeout=0, then go to HOLD.
REQ-029 WAIT watchdog: if TIMEOUT WAIT cycles elapse without fib_done, capture rsp_result=0, rsp_overflow=1 and rsp_timeout=1, then go to HOLD.
REQ-030 fib_n SHALL stay stable from ISSUE through the exit from WAIT.
REQ-031 HOLD: rsp_valid=1 and all rsp_* outputs stable; on rsp_ready=1, go to IDLE.
REQ-032 A back-pressured rsp_ready SHALL stall issue to the engine; the FIFO continues to accept requests until full.
REQ-033 Latency: a request accepted at edge t into an empty FIFO while in IDLE SHALL produce fib_go high in the cycle following edge t+2.
REQ-034 Latency: fib_done sampled in WAIT at edge e SHALL give rsp_valid high in the cycle following edge e.
REQ-035 All outputs SHALL be registered, except req_ready and pending, which are decoded from registered state.

Reset
REQ-036 While rst=0: state=IDLE; pointers, pending and the watchdog counter cleared; fib_go=0, fib_n=0, rsp_valid=0, rsp_n=0, rsp_result=0, rsp_overflow=0, rsp_timeout=0; req_ready=1.
REQ-037 Reset mid-operation SHALL discard all queued and in-flight requests without emitting a response.
REQ-038 The first request after reset release SHALL be issued normally.

Structure
REQ-039 Package fib_pkg SHALL hold the FSM state enum typedef and the default width constants shared with the fib engine.
REQ-040 The FIFO SHALL be a sub-module fib_req_fifo (push/pop, full/empty, count); the FSM and watchdog SHALL reside in fib_dispatcher.

Verification
REQ-041 Single request with the real fib engine: req_n=10, rsp_ready=1 -> one response with rsp_n=10, rsp_result=55, rsp_overflow=0, rsp_timeout=0.
REQ-042 Overflow: req_n=50 (RESULT_WIDTH=32) -> rsp_overflow=1, rsp_timeout=0.
REQ-043 Full FIFO: rsp_ready=0, push n=1..6 back-to-back -> 4 FIFO entries plus 1 in the engine, req_ready=0 on the 6th, pending=4; then release rsp_ready -> responses in order 1..5.
REQ-044 Stale done: engine stub holds fib_done=1 across go -> no capture in ARM; capture only on the next fresh done.
REQ-045 Timeout: stub never asserts done, TIMEOUT=15 -> rsp_valid after 15 WAIT cycles, with rsp_timeout=1, rsp_overflow=1, rsp_result=0.
REQ-046 Reset mid-WAIT with 2 entries queued -> all outputs at their reset values, pending=0, and no response after release.
